cci_mpf_shim_buffer_mc: RTL and testbench
=========================================

CCI_MPF_SHIM_BUFFER_MC -- requirements
Module: cci_mpf_shim_buffer_mc

Interface
REQ-001 The block SHALL take parameter N_CHANNELS, default 2: number of independent request channels, 1..8.
REQ-002 The block SHALL take parameter DATA_WIDTH, default 64: payload bits per channel.
REQ-003 The block SHALL take parameter N_ENTRIES, default 8: slots per channel FIFO, 2..64; non-power-of-two values SHALL be supported.
REQ-004 The block SHALL take parameter THRESHOLD, default 4: almost-full asserts when free slots <= THRESHOLD; it SHALL be less than N_ENTRIES.
REQ-005 The block SHALL take parameter BYPASS_MASK, default 0, N_CHANNELS bits wide: bit i set enables same-cycle bypass on channel i.
REQ-006 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 enq_en  input  N_CHANNELS  per-channel request valid.
REQ-009 enq_data  input  N_CHANNELS*DATA_WIDTH  per-channel payload; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 almost_full  output  N_CHANNELS  per-channel back-pressure to the producer.
REQ-011 first_valid  output  N_CHANNELS  head of channel i is valid.
REQ-012 first_data  output  N_CHANNELS*DATA_WIDTH  head payload per channel, using the same packing as enq_data.
REQ-013 deq_en  input  N_CHANNELS  consumer removes the head of channel i.
REQ-014 count  output  N_CHANNELS*CW  per-channel FIFO occupancy, where CW = $clog2(N_ENTRIES+1).
REQ-015 overflow_err  output  N_CHANNELS  sticky flag: an enqueue was dropped.
REQ-016 underflow_err  output  N_CHANNELS  sticky flag: deq_en was seen with no valid head.

Function
REQ-017 Channels SHALL be fully independent; no event on one channel SHALL alter the state or outputs of another.
REQ-018 Each channel SHALL be a circular FIFO with read and write pointers that wrap from N_ENTRIES-1 to 0.
REQ-019 Non-bypass latency: data enqueued in cycle N SHALL appear on first_data with first_valid=1 in cycle N+1.
REQ-020 almost_full[i] SHALL equal (N_ENTRIES - count[i]) <= THRESHOLD and SHALL depend only on registered state.
REQ-021 An enqueue while count=N_ENTRIES without a same-cycle deq SHALL be dropped; overflow_err[i] SHALL set and count SHALL be unchanged.
REQ-022 An enqueue while count=N_ENTRIES with a same-cycle valid deq SHALL be accepted; count SHALL stay at N_ENTRIES.
REQ-023 Simultaneous enq and deq on a non-empty, non-full FIFO SHALL leave count unchanged and advance both pointers.
REQ-024 deq_en[i] while first_valid[i]=0 SHALL be ignored and SHALL set underflow_err[i].
REQ-025 With BYPASS_MASK[i]=0: first_valid[i] SHALL equal count[i]!=0, and first_data[i] SHALL equal the FIFO head.
REQ-026 With BYPASS_MASK[i]=1 and count[i]=0: first_valid[i] SHALL equal enq_en[i], and first_data[i] SHALL equal enq_data[i] in the same cycle.
REQ-027 With BYPASS_MASK[i]=1, count=0, enq_en=1 and deq_en=1: the request SHALL be consumed without being written; count SHALL stay 0.
REQ-028 With BYPASS_MASK[i]=1 and count>0: the FIFO head SHALL take priority, and the new request SHALL be enqueued behind it, preserving order.
REQ-029 Sticky error flags SHALL clear only on reset.
REQ-030 Request order within a channel SHALL be strictly preserved under every combination of enq_en and deq_en.

Reset
REQ-031 While reset_n=0, all pointers and counts SHALL be 0.
REQ-032 While reset_n=0, first_valid, overflow_err and underflow_err SHALL be 0.
REQ-033 While reset_n=0, almost_full SHALL be 0 when THRESHOLD < N_ENTRIES.
REQ-034 Bypass outputs SHALL be forced invalid while reset_n=0.
REQ-035 Reset asserted mid-operation SHALL discard all buffered entries immediately (asynchronous).
REQ-036 Enqueues SHALL be accepted starting with the first rising edge after reset_n deasserts.
REQ-037 FIFO storage contents need no reset.

Verification
REQ-038 Defaults, channel 0: enqueue 0x11..0x18 on consecutive cycles, no deq -> count 1..8; almost_full rises when count=4; the 9th enqueue (0x19) sets overflow_err[0]; dequeue order is 0x11..0x18.
REQ-039 N_ENTRIES=6: run 20 enq/deq cycles to force pointer wrap -> data order preserved; count never exceeds 6.
REQ-040 BYPASS_MASK=2'b10, empty channel 1: enq 0xAB with deq in the same cycle -> first_data[1]=0xAB that cycle; count[1] stays 0; channel 0 unaffected.
REQ-041 Full channel with simultaneous enq 0x55 and deq -> head retired, 0x55 accepted at the tail, count stays 8, no overflow_err.
REQ-042 deq_en on an empty non-bypass channel -> underflow_err set and held until reset; count stays 0.
REQ-043 Assert reset_n=0 asynchronously with count=5 -> count, first_valid and error flags go to 0 before the next clock edge.

Source files
------------

// File: rtl/cci_mpf_shim_buffer_mc_if.sv
// Producer/consumer bundle for the multi-channel shim buffer.
// Fields are packed per channel, with channel i in slice i of each vector.
interface cci_mpf_shim_buffer_mc_if #(
   parameter int N_CHANNELS = 2,
   parameter int DATA_WIDTH = 64,
   parameter int N_ENTRIES  = 8
);
   localparam int CW = $clog2(N_ENTRIES + 1);

   logic [N_CHANNELS-1:0]            enq_en;
   logic [N_CHANNELS*DATA_WIDTH-1:0] enq_data;
   logic [N_CHANNELS-1:0]            almost_full;
   logic [N_CHANNELS-1:0]            first_valid;
   logic [N_CHANNELS*DATA_WIDTH-1:0] first_data;
   logic [N_CHANNELS-1:0]            deq_en;
   logic [N_CHANNELS*CW-1:0]         count;
   logic [N_CHANNELS-1:0]            overflow_err;
   logic [N_CHANNELS-1:0]            underflow_err;

   modport master (
      output enq_en, enq_data, deq_en,
      input  almost_full, first_valid, first_data, count, overflow_err, underflow_err
   );

   modport slave (
      input  enq_en, enq_data, deq_en,
      output almost_full, first_valid, first_data, count, overflow_err, underflow_err
   );
endinterface

// File: rtl/cci_mpf_shim_buffer_mc.sv
// Multi-channel request buffer: one independent circular FIFO per channel,
// with optional same-cycle bypass through an empty channel.
module cci_mpf_shim_buffer_mc #(
   parameter int                    N_CHANNELS  = 2,
   parameter int                    DATA_WIDTH  = 64,
   parameter int                    N_ENTRIES   = 8,
   parameter int                    THRESHOLD   = 4,
   parameter logic [N_CHANNELS-1:0] BYPASS_MASK = '0
) (
   input logic                     clk,
   input logic                     reset_n,
   cci_mpf_shim_buffer_mc_if.slave bus
);
   localparam int CW = $clog2(N_ENTRIES + 1);
   localparam int PW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

   logic [N_CHANNELS-1:0]            af_w;
   logic [N_CHANNELS-1:0]            fv_w;
   logic [N_CHANNELS-1:0]            ovf_w;
   logic [N_CHANNELS-1:0]            unf_w;
   logic [N_CHANNELS*DATA_WIDTH-1:0] fd_w;
   logic [N_CHANNELS*CW-1:0]         count_w;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(N_ENTRIES - 1)) ? '0 : p + 1'b1;
   endfunction

   for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
      logic [DATA_WIDTH-1:0] mem [N_ENTRIES];
      logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
      logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
      logic [CW-1:0]         count_q, count_d;
      logic                  ovf_q, ovf_d;
      logic                  unf_q, unf_d;
      logic                  enq, deq;
      logic [DATA_WIDTH-1:0] enq_word;
      logic                  empty, full, byp_empty;
      logic                  head_valid;
      logic [DATA_WIDTH-1:0] head_data;
      logic                  fifo_deq, byp_consume, enq_ok;

      assign enq      = bus.enq_en[i];
      assign deq      = bus.deq_en[i];
      assign enq_word = bus.enq_data[i*DATA_WIDTH +: DATA_WIDTH];

      // A bypassed request that is consumed in the same cycle never touches storage.
      always_comb begin
         empty       = (count_q == '0);
         full        = (count_q == CW'(N_ENTRIES));
         byp_empty   = BYPASS_MASK[i] && empty;
         head_valid  = reset_n && (byp_empty ? enq : !empty);
         head_data   = byp_empty ? enq_word : mem[rd_ptr_q];
         fifo_deq    = deq && !empty;
         byp_consume = byp_empty && enq && deq;
         enq_ok      = enq && !byp_consume && (!full || fifo_deq);
         rd_ptr_d    = fifo_deq ? ptr_inc(rd_ptr_q) : rd_ptr_q;
         wr_ptr_d    = enq_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
         count_d     = count_q + CW'(enq_ok) - CW'(fifo_deq);
         ovf_d       = ovf_q | (enq && full && !fifo_deq);
         unf_d       = unf_q | (deq && !head_valid);
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
         end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
         end
      end

      always_ff @(posedge clk) begin
         if (enq_ok) begin
            mem[wr_ptr_q] <= enq_word;
         end
      end

      assign af_w[i]                         = (N_ENTRIES - int'(count_q)) <= THRESHOLD;
      assign fv_w[i]                         = head_valid;
      assign fd_w[i*DATA_WIDTH +: DATA_WIDTH] = head_data;
      assign count_w[i*CW +: CW]             = count_q;
      assign ovf_w[i]                        = ovf_q;
      assign unf_w[i]                        = unf_q;
   end

   assign bus.almost_full   = af_w;
   assign bus.first_valid   = fv_w;
   assign bus.first_data    = fd_w;
   assign bus.count         = count_w;
   assign bus.overflow_err  = ovf_w;
   assign bus.underflow_err = unf_w;
endmodule

// File: tb/tb_cci_mpf_shim_buffer_mc.sv
// Directed bench for the shim buffer: default config, a 6-entry wrap config
// and a channel-1 bypass config, all sharing one clock and reset.
module tb_cci_mpf_shim_buffer_mc;
   logic clk;
   logic reset_n;

   cci_mpf_shim_buffer_mc_if #(.N_ENTRIES(8)) bus_a ();
   cci_mpf_shim_buffer_mc_if #(.N_ENTRIES(6)) bus_b ();
   cci_mpf_shim_buffer_mc_if #(.N_ENTRIES(8)) bus_c ();

   cci_mpf_shim_buffer_mc dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));
   cci_mpf_shim_buffer_mc #(.N_ENTRIES(6), .THRESHOLD(2)) dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));
   cci_mpf_shim_buffer_mc #(.BYPASS_MASK(2'b10)) dut_c (.clk(clk), .reset_n(reset_n), .bus(bus_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        enq;
      logic [63:0] data;
      logic        deq;
      int          exp_count;
      logic        exp_af;
      logic        exp_fv;
      logic [63:0] exp_fd;
      logic        exp_ovf;
      logic        exp_unf;
   } vec_t;

   vec_t        vecs [21];
   int          n_vectors;
   int          n_miscompares;
   logic [63:0] q [$];

   function automatic vec_t mk(input logic e, input logic [63:0] d, input logic dq, input int c,
                               input logic af, input logic fv, input logic [63:0] fd,
                               input logic ovf, input logic unf);
      vec_t v;
      v.enq = e; v.data = d; v.deq = dq; v.exp_count = c; v.exp_af = af;
      v.exp_fv = fv; v.exp_fd = fd; v.exp_ovf = ovf; v.exp_unf = unf;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_vectors++;
      if (actual !== expected) begin
         n_miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      bus_a.enq_en   = {1'b0, v.enq};
      bus_a.enq_data = {64'h0, v.data};
      bus_a.deq_en   = {1'b0, v.deq};
      @(posedge clk);
      #1;
      bus_a.enq_en = '0;
      bus_a.deq_en = '0;
   endtask

   task automatic cycle_a(input logic [1:0] e, input logic [127:0] d, input logic [1:0] dq);
      bus_a.enq_en = e; bus_a.enq_data = d; bus_a.deq_en = dq;
      @(posedge clk);
      #1;
      bus_a.enq_en = '0; bus_a.deq_en = '0;
   endtask

   task automatic cycle_c(input logic [1:0] e, input logic [127:0] d, input logic [1:0] dq);
      bus_c.enq_en = e; bus_c.enq_data = d; bus_c.deq_en = dq;
      @(posedge clk);
      #1;
      bus_c.enq_en = '0; bus_c.deq_en = '0;
   endtask

   // Watchdog so the run always ends even if a sequence stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [63:0] exp_list [8];
      logic        e, d, pop;

      n_vectors     = 0;
      n_miscompares = 0;

      vecs[0]  = mk(1, 64'h11, 0, 1, 0, 1, 64'h11, 0, 0);
      vecs[1]  = mk(1, 64'h12, 0, 2, 0, 1, 64'h11, 0, 0);
      vecs[2]  = mk(1, 64'h13, 0, 3, 0, 1, 64'h11, 0, 0);
      vecs[3]  = mk(1, 64'h14, 0, 4, 1, 1, 64'h11, 0, 0);
      vecs[4]  = mk(1, 64'h15, 0, 5, 1, 1, 64'h11, 0, 0);
      vecs[5]  = mk(1, 64'h16, 0, 6, 1, 1, 64'h11, 0, 0);
      vecs[6]  = mk(1, 64'h17, 0, 7, 1, 1, 64'h11, 0, 0);
      vecs[7]  = mk(1, 64'h18, 0, 8, 1, 1, 64'h11, 0, 0);
      vecs[8]  = mk(1, 64'h19, 0, 8, 1, 1, 64'h11, 1, 0);
      vecs[9]  = mk(0, 64'h0,  1, 7, 1, 1, 64'h12, 1, 0);
      vecs[10] = mk(0, 64'h0,  1, 6, 1, 1, 64'h13, 1, 0);
      vecs[11] = mk(0, 64'h0,  1, 5, 1, 1, 64'h14, 1, 0);
      vecs[12] = mk(0, 64'h0,  1, 4, 1, 1, 64'h15, 1, 0);
      vecs[13] = mk(0, 64'h0,  1, 3, 0, 1, 64'h16, 1, 0);
      vecs[14] = mk(0, 64'h0,  1, 2, 0, 1, 64'h17, 1, 0);
      vecs[15] = mk(0, 64'h0,  1, 1, 0, 1, 64'h18, 1, 0);
      vecs[16] = mk(0, 64'h0,  1, 0, 0, 0, 64'h0,  1, 0);
      vecs[17] = mk(0, 64'h0,  1, 0, 0, 0, 64'h0,  1, 1);
      vecs[18] = mk(1, 64'h20, 0, 1, 0, 1, 64'h20, 1, 1);
      vecs[19] = mk(1, 64'h21, 1, 1, 0, 1, 64'h21, 1, 1);
      vecs[20] = mk(0, 64'h0,  0, 1, 0, 1, 64'h21, 1, 1);

      reset_n = 1'b0;
      bus_a.enq_en = '0; bus_a.enq_data = '0; bus_a.deq_en = '0;
      bus_b.enq_en = '0; bus_b.enq_data = '0; bus_b.deq_en = '0;
      bus_c.enq_en = 2'b10; bus_c.enq_data = {64'hAB, 64'h0}; bus_c.deq_en = '0;

      // Outputs held quiet while reset is asserted, including the bypass path.
      #2;
      checkOutput("rst count_a", 64'(bus_a.count), 64'h0);
      checkOutput("rst fv_a", 64'(bus_a.first_valid), 64'h0);
      checkOutput("rst af_a", 64'(bus_a.almost_full), 64'h0);
      checkOutput("rst ovf_a", 64'(bus_a.overflow_err), 64'h0);
      checkOutput("rst unf_a", 64'(bus_a.underflow_err), 64'h0);
      checkOutput("rst count_b", 64'(bus_b.count), 64'h0);
      checkOutput("rst af_b", 64'(bus_b.almost_full), 64'h0);
      checkOutput("rst fv_c bypass", 64'(bus_c.first_valid), 64'h0);
      bus_c.enq_en = '0;

      @(negedge clk);
      reset_n = 1'b1;

      // Fill/overflow/drain/underflow sequence on channel 0 of the default config.
      for (int i = 0; i < 21; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("v%0d count0", i), 64'(bus_a.count[3:0]), 64'(vecs[i].exp_count));
         checkOutput($sformatf("v%0d af0", i), 64'(bus_a.almost_full[0]), 64'(vecs[i].exp_af));
         checkOutput($sformatf("v%0d fv0", i), 64'(bus_a.first_valid[0]), 64'(vecs[i].exp_fv));
         if (vecs[i].exp_fv) begin
            checkOutput($sformatf("v%0d fd0", i), bus_a.first_data[63:0], vecs[i].exp_fd);
         end
         checkOutput($sformatf("v%0d ovf0", i), 64'(bus_a.overflow_err[0]), 64'(vecs[i].exp_ovf));
         checkOutput($sformatf("v%0d unf0", i), 64'(bus_a.underflow_err[0]), 64'(vecs[i].exp_unf));
         checkOutput($sformatf("v%0d count1 idle", i), 64'(bus_a.count[7:4]), 64'h0);
         checkOutput($sformatf("v%0d ovf1 idle", i), 64'(bus_a.overflow_err[1]), 64'h0);
      end

      // Full channel 1: simultaneous enq and deq keeps count at 8 with no overflow.
      for (int j = 0; j < 8; j++) begin
         cycle_a(2'b10, {64'hA1 + 64'(j), 64'h0}, 2'b00);
      end
      checkOutput("full count1", 64'(bus_a.count[7:4]), 64'h8);
      checkOutput("full af1", 64'(bus_a.almost_full[1]), 64'h1);
      bus_a.enq_en = 2'b10; bus_a.enq_data = {64'h55, 64'h0}; bus_a.deq_en = 2'b10;
      #1;
      checkOutput("full head1", bus_a.first_data[127:64], 64'hA1);
      @(posedge clk);
      #1;
      bus_a.enq_en = '0; bus_a.deq_en = '0;
      checkOutput("full enqdeq count1", 64'(bus_a.count[7:4]), 64'h8);
      checkOutput("full enqdeq ovf1", 64'(bus_a.overflow_err[1]), 64'h0);
      for (int j = 0; j < 7; j++) exp_list[j] = 64'hA2 + 64'(j);
      exp_list[7] = 64'h55;
      for (int j = 0; j < 8; j++) begin
         checkOutput($sformatf("drain1 %0d", j), bus_a.first_data[127:64], exp_list[j]);
         cycle_a(2'b00, '0, 2'b10);
      end
      checkOutput("drain1 count", 64'(bus_a.count[7:4]), 64'h0);
      checkOutput("drain1 unf1", 64'(bus_a.underflow_err[1]), 64'h0);
      checkOutput("drain1 count0 untouched", 64'(bus_a.count[3:0]), 64'h1);

      // Six-entry channel: mixed enq/deq forces both pointers to wrap.
      q = {};
      for (int k = 0; k < 20; k++) begin
         e = (k % 5 != 4);
         d = (k >= 3) && (k % 3 != 0);
         bus_b.enq_en = {1'b0, e}; bus_b.enq_data = {64'h0, 64'h30 + 64'(k)}; bus_b.deq_en = {1'b0, d};
         #1;
         if (d && q.size() > 0) begin
            checkOutput($sformatf("wrap head k%0d", k), bus_b.first_data[63:0], q[0]);
         end
         pop = d && q.size() > 0;
         if (pop) void'(q.pop_front());
         if (e && (q.size() < 6 || pop)) q.push_back(64'h30 + 64'(k));
         @(posedge clk);
         #1;
         bus_b.enq_en = '0; bus_b.deq_en = '0;
         checkOutput($sformatf("wrap count k%0d", k), 64'(bus_b.count[2:0]), 64'(q.size()));
      end
      while (q.size() > 0) begin
         checkOutput("wrap drain", bus_b.first_data[63:0], q[0]);
         void'(q.pop_front());
         bus_b.deq_en = 2'b01;
         @(posedge clk);
         #1;
         bus_b.deq_en = '0;
      end
      checkOutput("wrap final count", 64'(bus_b.count[2:0]), 64'h0);
      checkOutput("wrap ovf", 64'(bus_b.overflow_err[0]), 64'h0);

      // Bypass channel: same-cycle pass-through, then head priority with ordering.
      bus_c.enq_en = 2'b10; bus_c.enq_data = {64'hAB, 64'h0}; bus_c.deq_en = 2'b10;
      #1;
      checkOutput("byp fv1", 64'(bus_c.first_valid[1]), 64'h1);
      checkOutput("byp fd1", bus_c.first_data[127:64], 64'hAB);
      checkOutput("byp fv0 unaffected", 64'(bus_c.first_valid[0]), 64'h0);
      @(posedge clk);
      #1;
      bus_c.enq_en = '0; bus_c.deq_en = '0;
      checkOutput("byp count1", 64'(bus_c.count[7:4]), 64'h0);
      checkOutput("byp unf1", 64'(bus_c.underflow_err[1]), 64'h0);
      checkOutput("byp count0", 64'(bus_c.count[3:0]), 64'h0);
      cycle_c(2'b10, {64'hC1, 64'h0}, 2'b00);
      checkOutput("byp store count1", 64'(bus_c.count[7:4]), 64'h1);
      bus_c.enq_en = 2'b10; bus_c.enq_data = {64'hC2, 64'h0};
      #1;
      checkOutput("byp head priority", bus_c.first_data[127:64], 64'hC1);
      @(posedge clk);
      #1;
      bus_c.enq_en = '0;
      checkOutput("byp queued count1", 64'(bus_c.count[7:4]), 64'h2);
      cycle_c(2'b00, '0, 2'b10);
      checkOutput("byp order second", bus_c.first_data[127:64], 64'hC2);
      cycle_c(2'b00, '0, 2'b10);
      checkOutput("byp drained count1", 64'(bus_c.count[7:4]), 64'h0);

      // Fresh reset, load five entries, then assert reset mid-cycle.
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      cycle_a(2'b01, {64'h0, 64'h61}, 2'b10);
      checkOutput("post-rst first enq", 64'(bus_a.count[3:0]), 64'h1);
      checkOutput("post-rst unf1", 64'(bus_a.underflow_err[1]), 64'h1);
      for (int j = 1; j < 5; j++) begin
         cycle_a(2'b01, {64'h0, 64'h61 + 64'(j)}, 2'b00);
      end
      checkOutput("pre-rst count0", 64'(bus_a.count[3:0]), 64'h5);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("async rst count0", 64'(bus_a.count[3:0]), 64'h0);
      checkOutput("async rst fv0", 64'(bus_a.first_valid[0]), 64'h0);
      checkOutput("async rst unf1", 64'(bus_a.underflow_err[1]), 64'h0);
      checkOutput("async rst af0", 64'(bus_a.almost_full[0]), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end
endmodule
